phased_delay_array: RTL



---
 rtl/phased_delay_array.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/phased_delay_array.sv
// phased_delay_array
// Samples a 1-bit pulse stream once every DIV clocks into a circular bit
// buffer and presents N_CH phase-stepped taps. Tap k carries the sample taken
// k*unit_delay strobes earlier. unit_delay is reprogrammed through a
// valid/ready handshake and applied at the next sample strobe, which also
// flushes the buffer history.
//
// Optional feature (macro PHASED_DELAY_REVERSE_EN): adds a cfg_dir input that
// is captured with a legal config request. When applied with cfg_dir=1, the
// phase order is reversed, so taps[N_CH-1-k] carries sample n-k*D.

module phased_delay_array #(
  parameter int N_CH     = 10,
  parameter int DEPTH    = 1024,
  parameter int AW       = 10,
  parameter int DIV      = 4,
  parameter int UNIT_RST = 86
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            din,
  input  logic [AW-1:0]   cfg_unit,
  input  logic            cfg_valid,
`ifdef PHASED_DELAY_REVERSE_EN
  input  logic            cfg_dir,
`endif
  output logic            cfg_ready,
  output logic            cfg_err,
  output logic [AW-1:0]   unit_delay,
  output logic [N_CH-1:0] taps,
  output logic            sample_stb
);

  // Divider counter width. A width of at least 1 is kept so that DIV=1 still
  // has a legal, constant-zero counter.
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

  // Product width for k*D and (N_CH-1)*cfg_unit. This width is wide enough
  // that neither product can truncate.
  localparam int PW = AW + $clog2(N_CH) + 1;

  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [AW:0]    FILL_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    FILL_ONE = (AW + 1)'(1);
  localparam logic [PW-1:0]  DEPTH_PW = PW'(DEPTH);
  localparam logic [PW-1:0]  LAST_TAP = PW'(N_CH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DCW-1:0]  div_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     fill;
  logic [AW-1:0]   unit_q;
  logic            pend_vld;
  logic [AW-1:0]   pend_unit;
  logic            cfg_err_q;
  logic [N_CH-1:0] taps_q;
  logic            stb_q;
  logic            mem [DEPTH];

`ifdef PHASED_DELAY_REVERSE_EN
  logic            dir_q;
  logic            pend_dir;
  logic            dir_next;
`endif

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic            strobe;
  logic            apply;
  logic            cfg_accept;
  logic            cfg_legal;
  logic [PW-1:0]   cfg_span;
  logic [AW-1:0]   unit_next;
  logic [AW:0]     fill_next;
  logic [N_CH-1:0] tap_next;
  logic [PW-1:0]   tap_off  [N_CH];
  logic [AW-1:0]   tap_addr [N_CH];
  logic [N_CH-1:0] tap_val;

  assign strobe     = en && (div_cnt == DIV_LAST);
  assign apply      = strobe && pend_vld;
  assign cfg_ready  = !pend_vld;
  assign cfg_accept = cfg_valid && cfg_ready;

  // Widen both operands before multiplying. This stops a large cfg_unit from
  // wrapping into the legal range.
  assign cfg_span  = LAST_TAP * PW'(cfg_unit);
  assign cfg_legal = (cfg_span < DEPTH_PW);

  // A strobe that applies a pending config uses the new spacing right away.
  // It also restarts the history with only the sample being written.
  assign unit_next = apply ? pend_unit : unit_q;
  assign fill_next = apply ? FILL_ONE
                   : ((fill == FILL_MAX) ? fill : fill + FILL_ONE);

`ifdef PHASED_DELAY_REVERSE_EN
  assign dir_next = apply ? pend_dir : dir_q;
`endif

  // Next tap vector, as seen immediately after the write on this strobe.
  always_comb begin
    // NOTE: every variable written here gets a default before any condition,
    // so no path leaves a value unassigned and no latch is inferred.
    tap_next = '0;
    tap_val  = '0;
    for (int k = 0; k < N_CH; k++) begin
      // NOTE: blocking '=' is correct inside combinational logic. Later
      // statements in this loop read the values computed just above them.
      tap_off[k]  = PW'(k) * PW'(unit_next);
      tap_addr[k] = wr_ptr - tap_off[k][AW-1:0];
      // Offset 0 is the sample being written on this edge. It is not in the
      // buffer yet, so it comes directly from din.
      tap_val[k]  = (tap_off[k] == '0) ? din : mem[tap_addr[k]];
      if (tap_off[k] < PW'(fill_next)) begin
`ifdef PHASED_DELAY_REVERSE_EN
        if (dir_next) tap_next[N_CH-1-k] = tap_val[k];
        else          tap_next[k]        = tap_val[k];
`else
        tap_next[k] = tap_val[k];
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Sample-rate divider. It freezes while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DCW'(1);
    end
  end

  // Circular sample buffer.
  // NOTE: the storage array has no reset on purpose. The fill count gates
  // every read, so stale contents are never seen at the taps.
  always_ff @(posedge clk) begin
    if (strobe) begin
      mem[wr_ptr] <= din;
    end
  end

  // Write pointer and valid-history count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (strobe) begin
      wr_ptr <= wr_ptr + AW'(1);
      fill   <= fill_next;
    end
  end

  // Config handshake: latch a legal request, then apply it on the next strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_unit <= '0;
      unit_q    <= AW'(UNIT_RST);
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_accept && !cfg_legal;
      if (apply) begin
        pend_vld <= 1'b0;
        unit_q   <= pend_unit;
      end
      if (cfg_accept && cfg_legal) begin
        pend_vld  <= 1'b1;
        pend_unit <= cfg_unit;
      end
    end
  end

`ifdef PHASED_DELAY_REVERSE_EN
  // Direction is captured and applied in step with unit_delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dir <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      if (apply) dir_q <= pend_dir;
      if (cfg_accept && cfg_legal) pend_dir <= cfg_dir;
    end
  end
`endif

  // Registered tap outputs. The strobe flag is delayed to line up with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      stb_q <= strobe;
      if (strobe) begin
        taps_q <= tap_next;
      end
    end
  end

  assign taps       = taps_q;
  assign sample_stb = stb_q;
  assign cfg_err    = cfg_err_q;
  assign unit_delay = unit_q;

endmodule
